// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants that the memory port arbiter and its
// timer share.
//   arb_state_e   - arbiter FSM state (IDLE, ACC_IF, ACC_DM)
//   STARVE_LIMIT_DEF, WAIT_LIMIT_DEF - default parameter values
//   TIMEOUT_DATA  - read data returned to a requester whose access timed out
//   CNT_W         - width of the starvation and wait counters
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_DM = 2'd2
    } arb_state_e;

    localparam int          STARVE_LIMIT_DEF = 4;
    localparam int          WAIT_LIMIT_DEF   = 15;
    localparam logic [31:0] TIMEOUT_DATA     = 32'h0;
    localparam int          CNT_W            = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the instruction-fetch port, the data port, the
// shared memory port and the status outputs of the arbiter.
//   master - arbiter side: takes requests and memory responses, and drives
//            completions, the memory access and the status signals
//   slave  - environment side (the two requesters and the memory)
interface mem_port_arbiter_if;
    // instruction fetch
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    // data
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    // shared memory
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // status
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts the cycles an access waits for mem_ack.
//   clk, reset - clock, asynchronous active-low reset
//   clear      - restart from zero (access granted)
//   count      - one more cycle without mem_ack
//   limit      - number of unacknowledged cycles allowed
//   expired    - this cycle is the limit-th cycle without mem_ack
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         count,
    input  logic [W-1:0] limit,
    output logic         expired
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_wait_cnt <= '0;
        else if (clear)  r_wait_cnt <= '0;
        else if (count)  r_wait_cnt <= r_wait_cnt + ONE;
    end

    // Fires on the edge at which the count would reach the limit, so the
    // access has had exactly `limit` cycles to be acknowledged.
    assign expired = count & ((r_wait_cnt + ONE) == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port. Data has priority unless fetch has been passed over
// STARVE_LIMIT times in a row. An access that sees no mem_ack within
// WAIT_LIMIT cycles is abandoned with an err pulse and zero read data.
//   clk   - clock
//   reset - asynchronous active-low reset
//   bus   - fetch, data and memory ports plus stall/err status (master view)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int WAIT_LIMIT   = WAIT_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] WAIT_MAX   = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_e       r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_mem_en, r_mem_we;
    logic [31:0]      r_mem_addr, r_mem_wdata;
    logic [31:0]      r_if_rdata, r_dm_rdata;
    logic             r_if_ready, r_dm_ready, r_err;

    logic w_pick_if, w_pick_dm, w_grant_if, w_grant_dm;
    logic w_in_acc, w_expired;

    // Priority is decided on the raw requests. If the winner is the requester
    // completing this cycle, its request is stale and nobody is granted; the
    // other port is only granted here when it would have won anyway.
    assign w_pick_if  = bus.if_req & (~bus.dm_req | (r_starve_cnt == STARVE_MAX));
    assign w_pick_dm  = bus.dm_req & ~w_pick_if;
    assign w_grant_if = (r_state == IDLE) & w_pick_if & ~r_if_ready;
    assign w_grant_dm = (r_state == IDLE) & w_pick_dm & ~r_dm_ready;
    assign w_in_acc   = (r_state == ACC_IF) | (r_state == ACC_DM);

    mem_arb_timer #(.W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_grant_if | w_grant_dm),
        .count   (w_in_acc & ~bus.mem_ack),
        .limit   (WAIT_MAX),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_err      <= 1'b0;

            if (!bus.if_req || w_grant_if)
                r_starve_cnt <= '0;
            else if (w_grant_dm && r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + CNT_ONE;

            case (r_state)
                IDLE: begin
                    if (w_grant_dm) begin
                        r_state     <= ACC_DM;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= bus.dm_we;
                        r_mem_addr  <= bus.dm_addr;
                        r_mem_wdata <= bus.dm_wdata;
                    end else if (w_grant_if) begin
                        r_state     <= ACC_IF;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                ACC_IF, ACC_DM: begin
                    // mem_ack wins over a simultaneous timeout.
                    if (bus.mem_ack || w_expired) begin
                        r_state  <= IDLE;
                        r_mem_en <= 1'b0;
                        r_err    <= ~bus.mem_ack;
                        if (r_state == ACC_IF) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= bus.mem_ack ? bus.mem_rdata : TIMEOUT_DATA;
                        end else begin
                            r_dm_ready <= 1'b1;
                            if (!bus.mem_ack)
                                r_dm_rdata <= TIMEOUT_DATA;
                            else if (!r_mem_we)
                                r_dm_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_ready  = r_dm_ready;
    assign bus.err       = r_err;
    assign bus.stall_if  = bus.if_req & ~r_if_ready;
    assign bus.stall_mem = bus.dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for
// mem_port_arbiter (STARVE_LIMIT=4, WAIT_LIMIT=15).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   w;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4), .WAIT_LIMIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus.mem_rdata = 0; bus.mem_ack = 0;

        // reset state
        step(); step();
        chk("rst_mem_en",   32'(bus.mem_en), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_ready",    32'({bus.if_ready, bus.dm_ready, bus.err}), 0);
        reset = 1'b1;
        step();

        // isolated fetch read, minimum latency
        bus.if_req = 1; bus.if_addr = 32'h40;
        #1 chk("if_stall_c0", 32'(bus.stall_if), 1);
        step();
        chk("if_en_c1",    32'(bus.mem_en), 1);
        chk("if_addr_c1",  bus.mem_addr, 32'h40);
        chk("if_we_c1",    32'({bus.mem_we, bus.mem_wdata != 0}), 0);
        chk("if_stall_c1", 32'(bus.stall_if), 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h1234ABCD;
        step();
        chk("if_ready_c2", 32'(bus.if_ready), 1);
        chk("if_rdata_c2", bus.if_rdata, 32'h1234ABCD);
        chk("if_en_c2",    32'(bus.mem_en), 0);
        chk("if_stall_c2", 32'(bus.stall_if), 0);
        bus.mem_ack = 0;
        step();
        // request still high in the ready cycle must not be re-granted
        chk("if_nogrant_c3", 32'({bus.mem_en, bus.if_ready}), 0);
        bus.if_req = 0;
        step();

        // mem_ack while idle is ignored
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF0000;
        step();
        chk("idle_ack_rdy",   32'({bus.if_ready, bus.dm_ready, bus.err}), 0);
        chk("idle_ack_rdata", bus.if_rdata, 32'h1234ABCD);
        bus.mem_ack = 0;
        step();

        // simultaneous requests: data write first, then fetch
        bus.if_req = 1; bus.if_addr = 32'h80;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'h55;
        step();
        chk("sim_dm_en",    32'(bus.mem_en), 1);
        chk("sim_dm_we",    32'(bus.mem_we), 1);
        chk("sim_dm_addr",  bus.mem_addr, 32'h100);
        chk("sim_dm_wdata", bus.mem_wdata, 32'h55);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD0000;
        step();
        chk("sim_dm_ready", 32'({bus.dm_ready, bus.if_ready}), 32'h2);
        chk("sim_dm_rdata", bus.dm_rdata, 0);
        bus.mem_ack = 0; bus.dm_req = 0; bus.dm_we = 0;
        step();
        chk("sim_if_en",    32'(bus.mem_en), 1);
        chk("sim_if_addr",  bus.mem_addr, 32'h80);
        chk("sim_if_we",    32'({bus.mem_we, bus.mem_wdata != 0}), 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D;
        step();
        chk("sim_if_ready", 32'({bus.dm_ready, bus.if_ready}), 32'h1);
        chk("sim_if_rdata", bus.if_rdata, 32'h0BADF00D);
        bus.mem_ack = 0; bus.if_req = 0;
        step();

        // starvation: grants go D,D,D,D,I then D again once the count clears
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300;
        for (int g = 1; g <= 6; g++) begin
            w = 0;
            while (!bus.mem_en && w < 6) begin
                step();
                w++;
            end
            chk($sformatf("starve_en_g%0d", g), 32'(bus.mem_en), 1);
            chk($sformatf("starve_addr_g%0d", g), bus.mem_addr, (g == 5) ? 32'h200 : 32'h300);
            bus.mem_ack = 1; bus.mem_rdata = 32'h1000 + g;
            step();
            bus.mem_ack = 0;
        end
        bus.if_req = 0; bus.dm_req = 0;
        chk("starve_if_rdata", bus.if_rdata, 32'h1005);
        chk("starve_dm_rdata", bus.dm_rdata, 32'h1006);
        step();

        // timeout: 15 unacknowledged access cycles
        bus.dm_req = 1; bus.dm_addr = 32'h400;
        step();
        chk("to_en_acc1",   32'(bus.mem_en), 1);
        chk("to_stall_mem", 32'(bus.stall_mem), 1);
        repeat (14) step();
        chk("to_acc15", 32'({bus.err, bus.mem_en, bus.dm_ready}), 32'h2);
        step();
        chk("to_err",       32'(bus.err), 1);
        chk("to_dm_ready",  32'(bus.dm_ready), 1);
        chk("to_dm_rdata",  bus.dm_rdata, 0);
        chk("to_en_off",    32'(bus.mem_en), 0);
        chk("to_stall_off", 32'(bus.stall_mem), 0);
        bus.dm_req = 0;
        step();
        chk("to_err_pulse", 32'({bus.err, bus.dm_ready}), 0);

        // ack on the 15th access cycle beats the timeout
        bus.dm_req = 1; bus.dm_addr = 32'h404;
        step();
        repeat (14) step();
        bus.mem_ack = 1; bus.mem_rdata = 32'h77;
        step();
        chk("ack15_err",   32'(bus.err), 0);
        chk("ack15_ready", 32'(bus.dm_ready), 1);
        chk("ack15_rdata", bus.dm_rdata, 32'h77);
        bus.mem_ack = 0; bus.dm_req = 0;
        step();

        // reset in the middle of a fetch access
        bus.if_req = 1; bus.if_addr = 32'h500;
        step();
        chk("rma_en", 32'(bus.mem_en), 1);
        reset = 1'b0;
        #1;
        chk("rma_en_async", 32'(bus.mem_en), 0);
        chk("rma_rdata",    bus.if_rdata, 0);
        bus.if_req = 0;
        step();
        chk("rma_no_ready", 32'(bus.if_ready), 0);
        reset = 1'b1;
        step();
        chk("rma_idle", 32'({bus.if_ready, bus.mem_en}), 0);
        bus.if_req = 1; bus.if_addr = 32'h504;
        step();
        chk("rma_new_addr", bus.mem_addr, 32'h504);
        bus.mem_ack = 1; bus.mem_rdata = 32'h99;
        step();
        chk("rma_new_ready", 32'(bus.if_ready), 1);
        chk("rma_new_rdata", bus.if_rdata, 32'h99);
        bus.mem_ack = 0; bus.if_req = 0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
